tvs_scan_sequencer: RTL and testbench

- Round-robin scheduler for the PF_TVS temperature/voltage monitor: enables one TVS channel at a time and waits for its conversion.
- Captures each result into a 4-entry shadow register file and emits a one-cycle write strobe toward the URAM writer.
- Serves a 1-cycle-latency read port for the slow-control path.
- Sits between PF_TVS and the URAM/register interface; replaces free-running TVS capture with a paced, timeout-guarded scan.

---
 rtl/tvs_pkg.sv | 36 +++
 rtl/tvs_shadow_rf.sv | 48 ++++
 rtl/tvs_scan_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_tvs_scan_sequencer.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tvs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tvs_pkg
// Description : Shared types and constants for the PF_TVS scan sequencer.
// Revision    : 1.0  initial release
// ============================================================================
package tvs_pkg;

    localparam int TVS_NCH   = 4;
    localparam int TVS_CH_W  = 2;
    localparam int TVS_VAL_W = 16;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        SELECT     = 3'd1,
        WAIT_VALID = 3'd2,
        STORE      = 3'd3,
        NEXT       = 3'd4,
        PERIOD     = 3'd5
    } tvs_state_e;

    // Lowest masked channel at index >= lo; MSB of the result is the found flag.
    function automatic logic [TVS_CH_W:0] tvs_pick_ch(input logic [TVS_NCH-1:0] mask,
                                                     input logic [TVS_CH_W:0]  lo);
        logic [TVS_CH_W:0] r;
        r = '0;
        for (int i = TVS_NCH - 1; i >= 0; i--) begin
            if (mask[i] && (i >= int'(lo))) begin
                r = {1'b1, TVS_CH_W'(i)};
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tvs_shadow_rf.sv
`default_nettype none
// ============================================================================
// Module      : tvs_shadow_rf
// Description : 4x16 shadow register file, write-first read with 1-cycle ack.
// Revision    : 1.0  initial release
// ============================================================================
module tvs_shadow_rf
    import tvs_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_wr_en,
    input  logic [TVS_CH_W-1:0]  i_wr_addr,
    input  logic [TVS_VAL_W-1:0] i_wr_data,
    input  logic                 i_rd_req,
    input  logic [TVS_CH_W-1:0]  i_rd_addr,
    output logic                 o_rd_ack,
    output logic [TVS_VAL_W-1:0] o_rd_data
);

    logic [TVS_VAL_W-1:0] r_mem [TVS_NCH];
    logic                 r_rd_ack;
    logic [TVS_VAL_W-1:0] r_rd_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TVS_NCH; i++) begin
                r_mem[i] <= '0;
            end
            r_rd_ack  <= 1'b0;
            r_rd_data <= '0;
        end else begin
            if (i_wr_en) begin
                r_mem[i_wr_addr] <= i_wr_data;
            end
            r_rd_ack <= i_rd_req;
            // A same-cycle write to the read address bypasses the array.
            if (i_rd_req) begin
                r_rd_data <= (i_wr_en && (i_wr_addr == i_rd_addr)) ? i_wr_data : r_mem[i_rd_addr];
            end
        end
    end

    assign o_rd_ack  = r_rd_ack;
    assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/tvs_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tvs_scan_sequencer
// Description : Paced, timeout-guarded round-robin PF_TVS channel scanner with
//               shadow register file. Optional alarm outputs via TVS_ALARM_EN.
// Revision    : 1.0  initial release
// ============================================================================
module tvs_scan_sequencer
    import tvs_pkg::*;
#(
    parameter int                 SCAN_PERIOD = 1000,
    parameter int                 TIMEOUT     = 4096,
    parameter logic [TVS_NCH-1:0] CH_MASK     = 4'b1111
) (
    input  logic                 clk,
    input  logic                 reset_i,
    input  logic                 scan_en_i,
    output logic [TVS_NCH-1:0]   tvs_en_o,
    input  logic                 tvs_valid_i,
    input  logic [TVS_VAL_W-1:0] tvs_value_i,
    input  logic [TVS_CH_W-1:0]  tvs_channel_i,
    output logic                 wr_en_o,
    output logic [TVS_CH_W-1:0]  wr_addr_o,
    output logic [TVS_VAL_W-1:0] wr_data_o,
    input  logic                 rd_req_i,
    input  logic [TVS_CH_W-1:0]  rd_addr_i,
    output logic                 rd_ack_o,
    output logic [TVS_VAL_W-1:0] rd_data_o,
    output logic                 busy_o,
    output logic [TVS_NCH-1:0]   timeout_o,
    output logic [15:0]          scan_cnt_o
`ifdef TVS_ALARM_EN
    ,
    input  logic [TVS_VAL_W-1:0] alarm_thr_i,
    output logic [TVS_NCH-1:0]   alarm_o
`endif
);

    localparam int c_TO_W  = $clog2(TIMEOUT);
    localparam int c_PER_W = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
    localparam logic [c_TO_W-1:0]  c_TO_LAST  = c_TO_W'(TIMEOUT - 1);
    localparam logic [c_PER_W-1:0] c_PER_LAST = c_PER_W'(SCAN_PERIOD - 1);

    tvs_state_e r_state, w_state_nxt;

    logic                 r_valid_r, r_valid_rr;
    logic [TVS_VAL_W-1:0] r_value_r;
    logic [TVS_CH_W-1:0]  r_chan_r;
    logic [TVS_CH_W-1:0]  r_ch;
    logic [c_TO_W-1:0]    r_to_cnt;
    logic [c_PER_W-1:0]   r_per_cnt;
    logic [TVS_NCH-1:0]   r_timeout;
    logic [15:0]          r_scan_cnt;
    logic                 r_wr_en;
    logic [TVS_CH_W-1:0]  r_wr_addr;
    logic [TVS_VAL_W-1:0] r_wr_data;

    logic [TVS_CH_W:0]    w_first, w_next;
    logic                 w_hit, w_to_expire;
    logic [TVS_NCH-1:0]   w_tvs_en;
    logic                 w_busy;

    assign w_first     = tvs_pick_ch(CH_MASK, '0);
    assign w_next      = tvs_pick_ch(CH_MASK, {1'b0, r_ch} + 1'b1);
    assign w_hit       = r_valid_r && !r_valid_rr && (r_chan_r == r_ch);
    assign w_to_expire = (r_to_cnt == c_TO_LAST);

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:       if (scan_en_i && w_first[TVS_CH_W]) w_state_nxt = SELECT;
            SELECT:     w_state_nxt = WAIT_VALID;
            WAIT_VALID: begin
                if (w_hit)            w_state_nxt = STORE;
                else if (w_to_expire) w_state_nxt = NEXT;
            end
            STORE:      w_state_nxt = NEXT;
            NEXT:       w_state_nxt = w_next[TVS_CH_W] ? SELECT : PERIOD;
            PERIOD:     if (r_per_cnt == c_PER_LAST) w_state_nxt = scan_en_i ? SELECT : IDLE;
            default:    w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_tvs_en = '0;
        w_busy   = (r_state != IDLE);
        if ((r_state == SELECT) || (r_state == WAIT_VALID)) begin
            w_tvs_en[r_ch] = 1'b1;
        end
    end

    // The write strobe and data are registered on the WAIT_VALID->STORE edge so
    // they are live exactly for the STORE cycle with the edge-stage value.
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            r_valid_r  <= 1'b0;
            r_valid_rr <= 1'b0;
            r_value_r  <= '0;
            r_chan_r   <= '0;
            r_ch       <= '0;
            r_to_cnt   <= '0;
            r_per_cnt  <= '0;
            r_timeout  <= '0;
            r_scan_cnt <= '0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
        end else begin
            r_valid_r  <= tvs_valid_i;
            r_valid_rr <= r_valid_r;
            r_value_r  <= tvs_value_i;
            r_chan_r   <= tvs_channel_i;
            r_wr_en    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_state_nxt == SELECT) r_ch <= w_first[TVS_CH_W-1:0];
                end
                SELECT: begin
                    r_to_cnt <= '0;
                end
                WAIT_VALID: begin
                    r_to_cnt <= r_to_cnt + 1'b1;
                    if (w_hit) begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= r_ch;
                        r_wr_data <= r_value_r;
                    end else if (w_to_expire) begin
                        r_timeout[r_ch] <= 1'b1;
                    end
                end
                NEXT: begin
                    if (w_next[TVS_CH_W]) begin
                        r_ch <= w_next[TVS_CH_W-1:0];
                    end else begin
                        r_scan_cnt <= r_scan_cnt + 1'b1;
                        r_per_cnt  <= '0;
                    end
                end
                PERIOD: begin
                    r_per_cnt <= r_per_cnt + 1'b1;
                    if (w_state_nxt == SELECT) r_ch <= w_first[TVS_CH_W-1:0];
                end
                default: ;
            endcase
        end
    end

    tvs_shadow_rf u_shadow_rf (
        .clk       (clk),
        .rst       (reset_i),
        .i_wr_en   (r_wr_en),
        .i_wr_addr (r_wr_addr),
        .i_wr_data (r_wr_data),
        .i_rd_req  (rd_req_i),
        .i_rd_addr (rd_addr_i),
        .o_rd_ack  (rd_ack_o),
        .o_rd_data (rd_data_o)
    );

`ifdef TVS_ALARM_EN
    logic [TVS_NCH-1:0] r_alarm;

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            r_alarm <= '0;
        end else if (r_state == STORE) begin
            r_alarm[r_ch] <= (r_wr_data > alarm_thr_i);
        end
    end

    assign alarm_o = r_alarm;
`endif

    assign tvs_en_o   = w_tvs_en;
    assign busy_o     = w_busy;
    assign wr_en_o    = r_wr_en;
    assign wr_addr_o  = r_wr_addr;
    assign wr_data_o  = r_wr_data;
    assign timeout_o  = r_timeout;
    assign scan_cnt_o = r_scan_cnt;

endmodule
`default_nettype wire

// File: tb/tb_tvs_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_tvs_scan_sequencer
// Description : Self-checking bench for tvs_scan_sequencer (PF_TVS responder
//               plus shadow/flag/counter reference model).
// Revision    : 1.0  initial release
// ============================================================================
module tb_tvs_scan_sequencer;

    localparam int         SCAN_PERIOD = 1000;
    localparam int         TIMEOUT     = 64;
    localparam logic [3:0] CH_MASK     = 4'b1111;

    logic        clk = 1'b0;
    logic        reset_i, scan_en_i, tvs_valid_i, rd_req_i;
    logic [15:0] tvs_value_i;
    logic [1:0]  tvs_channel_i, rd_addr_i;
    logic [3:0]  tvs_en_o, timeout_o;
    logic        wr_en_o, rd_ack_o, busy_o;
    logic [1:0]  wr_addr_o;
    logic [15:0] wr_data_o, rd_data_o, scan_cnt_o;
`ifdef TVS_ALARM_EN
    logic [15:0] alarm_thr_i;
    logic [3:0]  alarm_o;
`endif

    always #5 clk = ~clk;

    tvs_scan_sequencer #(
        .SCAN_PERIOD (SCAN_PERIOD),
        .TIMEOUT     (TIMEOUT),
        .CH_MASK     (CH_MASK)
    ) dut (
        .clk           (clk),
        .reset_i       (reset_i),
        .scan_en_i     (scan_en_i),
        .tvs_en_o      (tvs_en_o),
        .tvs_valid_i   (tvs_valid_i),
        .tvs_value_i   (tvs_value_i),
        .tvs_channel_i (tvs_channel_i),
        .wr_en_o       (wr_en_o),
        .wr_addr_o     (wr_addr_o),
        .wr_data_o     (wr_data_o),
        .rd_req_i      (rd_req_i),
        .rd_addr_i     (rd_addr_i),
        .rd_ack_o      (rd_ack_o),
        .rd_data_o     (rd_data_o),
        .busy_o        (busy_o),
        .timeout_o     (timeout_o),
        .scan_cnt_o    (scan_cnt_o)
`ifdef TVS_ALARM_EN
        ,
        .alarm_thr_i   (alarm_thr_i),
        .alarm_o       (alarm_o)
`endif
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wr_seen = 0;
    int scan_end_cyc = 0;
    bit gap_chk = 1'b0;

    // Reference model state
    logic [15:0] m_shadow [4];
    logic [3:0]  m_timeout;
    logic [15:0] m_scan_cnt;
    logic [3:0]  m_alarm;

    // Per-scan plan
    logic [15:0] p_val [4];
    logic [3:0]  p_ans, p_wrong, p_rd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (wr_en_o === 1'b1) wr_seen++;
    endtask

    task automatic wait_en(output int n);
        n = 0;
        while (tvs_en_o == 4'b0 && n < 3000) begin
            tick();
            n++;
        end
    endtask

    task automatic do_channel(input int ch, input bit answer, input logic [15:0] value,
                              input bit wrong, input bit rd_same);
        int n, hold, wr0;
        logic [1:0] chv;
        chv = 2'(ch);
        wait_en(n);
        if (ch == 0 && gap_chk) check("period_len", cyc - scan_end_cyc, SCAN_PERIOD + 1);
        check("tvs_en_onehot", 32'(tvs_en_o), 32'(1) << ch);
        wr0 = wr_seen;
        if (!answer) begin
            n = 0;
            while (tvs_en_o != 4'b0 && n < 500) begin
                n++;
                tick();
            end
            m_timeout[ch] = 1'b1;
            check("timeout_len", n, TIMEOUT + 1);
            check("timeout_flags", 32'(timeout_o), 32'(m_timeout));
            check("no_write_on_timeout", wr_seen - wr0, 0);
            scan_end_cyc = cyc;
        end else begin
            repeat ($urandom_range(1, 8)) tick();
            if (wrong) begin
                tvs_valid_i   = 1'b1;
                tvs_channel_i = chv + 2'($urandom_range(1, 3));
                tvs_value_i   = 16'($urandom);
                repeat ($urandom_range(1, 3)) tick();
                tvs_valid_i = 1'b0;
                repeat ($urandom_range(2, 6)) tick();
                check("wrong_tag_no_write", wr_seen - wr0, 0);
                check("still_enabled", 32'(tvs_en_o), 32'(1) << ch);
            end
            hold          = $urandom_range(1, 3);
            tvs_valid_i   = 1'b1;
            tvs_channel_i = chv;
            tvs_value_i   = value;
            tick();
            tvs_value_i = ~value;
            if (hold == 1) tvs_valid_i = 1'b0;
            check("wr_not_early", 32'(wr_en_o), 0);
            tick();
            if (hold == 2) tvs_valid_i = 1'b0;
            check("wr_en_latency", 32'(wr_en_o), 1);
            check("wr_addr", 32'(wr_addr_o), 32'(ch));
            check("wr_data", 32'(wr_data_o), 32'(value));
            check("en_off_store", 32'(tvs_en_o), 0);
            m_shadow[ch] = value;
            if (rd_same) begin
                rd_req_i  = 1'b1;
                rd_addr_i = chv;
            end
            tick();
            tvs_valid_i = 1'b0;
            rd_req_i    = 1'b0;
            check("wr_en_one_cycle", 32'(wr_en_o), 0);
            check("wr_data_hold", 32'(wr_data_o), 32'(value));
            check("write_count", wr_seen - wr0, 1);
            if (rd_same) begin
                check("rd_ack_write_first", 32'(rd_ack_o), 1);
                check("rd_data_write_first", 32'(rd_data_o), 32'(value));
            end
`ifdef TVS_ALARM_EN
            m_alarm[ch] = (value > alarm_thr_i);
            check("alarm", 32'(alarm_o), 32'(m_alarm));
`endif
            scan_end_cyc = cyc;
        end
    endtask

    task automatic run_scan(input bit drop_en);
        for (int ch = 0; ch < 4; ch++) begin
            do_channel(ch, p_ans[ch], p_val[ch], p_wrong[ch], p_rd[ch]);
            if (ch == 0 && drop_en) scan_en_i = 1'b0;
        end
        m_scan_cnt++;
        tick();
        tick();
        check("scan_cnt", 32'(scan_cnt_o), 32'(m_scan_cnt));
        check("busy_in_period", 32'(busy_o), 1);
        check("en_off_period", 32'(tvs_en_o), 0);
        gap_chk = !drop_en;
    endtask

    task automatic read_burst(input int k);
        logic [1:0] prev;
        rd_req_i  = 1'b1;
        rd_addr_i = 2'($urandom_range(0, 3));
        prev      = rd_addr_i;
        for (int i = 0; i < k; i++) begin
            tick();
            check("rd_ack", 32'(rd_ack_o), 1);
            check("rd_data", 32'(rd_data_o), 32'(m_shadow[prev]));
            if (i < k - 1) begin
                rd_addr_i = 2'($urandom_range(0, 3));
                prev      = rd_addr_i;
            end else begin
                rd_req_i = 1'b0;
            end
        end
        tick();
        check("rd_ack_idle", 32'(rd_ack_o), 0);
        check("rd_data_hold", 32'(rd_data_o), 32'(m_shadow[prev]));
    endtask

    task automatic random_plan();
        for (int ch = 0; ch < 4; ch++) begin
            p_val[ch]   = 16'($urandom);
            p_ans[ch]   = ($urandom_range(0, 4) != 0);
            p_wrong[ch] = ($urandom_range(0, 3) == 0);
            p_rd[ch]    = ($urandom_range(0, 1) == 0);
        end
    endtask

    initial begin
        int n;
        reset_i       = 1'b1;
        scan_en_i     = 1'b0;
        tvs_valid_i   = 1'b0;
        tvs_value_i   = '0;
        tvs_channel_i = '0;
        rd_req_i      = 1'b0;
        rd_addr_i     = '0;
`ifdef TVS_ALARM_EN
        alarm_thr_i   = 16'h2000;
`endif
        for (int i = 0; i < 4; i++) m_shadow[i] = '0;
        m_timeout  = '0;
        m_scan_cnt = '0;
        m_alarm    = '0;

        repeat (3) tick();
        check("rst_tvs_en", 32'(tvs_en_o), 0);
        check("rst_busy", 32'(busy_o), 0);
        check("rst_wr_en", 32'(wr_en_o), 0);
        check("rst_scan_cnt", 32'(scan_cnt_o), 0);
        check("rst_timeout", 32'(timeout_o), 0);
        check("rst_rd_ack", 32'(rd_ack_o), 0);
        reset_i = 1'b0;
        tick();
        tick();
        check("idle_without_scan_en", 32'(busy_o), 0);
        scan_en_i = 1'b1;

        // All channels answer with 0x1000+ch
        p_val   = '{16'h1000, 16'h1001, 16'h1002, 16'h1003};
        p_ans   = 4'b1111;
        p_wrong = 4'b0000;
        p_rd    = 4'b0000;
        run_scan(1'b0);
        read_burst(4);

        // Channel 2 never answers
        p_val = '{16'h2001, 16'h2000, 16'h5555, 16'h0042};
        p_ans = 4'b1011;
        run_scan(1'b0);
        check("timeout_only_ch2", 32'(timeout_o), 32'h4);
`ifdef TVS_ALARM_EN
        check("alarm_threshold", 32'(alarm_o), 32'h1);
`endif

        // Wrong tag while waiting on ch1, then read colliding with its STORE
        random_plan();
        p_val[1] = 16'hABCD;
        p_ans    = 4'b1111;
        p_wrong  = 4'b0010;
        p_rd     = 4'b0010;
        run_scan(1'b0);
        read_burst(6);

        for (int s = 0; s < 5; s++) begin
            random_plan();
            run_scan(1'b0);
            read_burst($urandom_range(1, 5));
        end

        // Asynchronous reset while waiting on channel 1
        do_channel(0, 1'b1, 16'($urandom), 1'b0, 1'b0);
        wait_en(n);
        check("en_ch1_before_reset", 32'(tvs_en_o), 32'h2);
        repeat (3) tick();
        reset_i   = 1'b1;
        scan_en_i = 1'b0;
        #1;
        check("async_tvs_en", 32'(tvs_en_o), 0);
        check("async_busy", 32'(busy_o), 0);
        check("async_wr_en", 32'(wr_en_o), 0);
        check("async_wr_addr", 32'(wr_addr_o), 0);
        check("async_wr_data", 32'(wr_data_o), 0);
        check("async_rd_ack", 32'(rd_ack_o), 0);
        check("async_rd_data", 32'(rd_data_o), 0);
        check("async_timeout", 32'(timeout_o), 0);
        check("async_scan_cnt", 32'(scan_cnt_o), 0);
`ifdef TVS_ALARM_EN
        check("async_alarm", 32'(alarm_o), 0);
`endif
        for (int i = 0; i < 4; i++) m_shadow[i] = '0;
        m_timeout  = '0;
        m_scan_cnt = '0;
        m_alarm    = '0;
        gap_chk    = 1'b0;
        tick();
        tick();
        reset_i = 1'b0;
        tick();
        read_burst(3);

        // Restart from channel 0; drop scan_en_i mid-scan
        scan_en_i = 1'b1;
        random_plan();
        run_scan(1'b1);
        n = 0;
        while (busy_o && n < 3000) begin
            tick();
            n++;
        end
        check("idle_after_period", cyc - scan_end_cyc, SCAN_PERIOD + 1);
        repeat (50) tick();
        check("stays_idle_busy", 32'(busy_o), 0);
        check("stays_idle_en", 32'(tvs_en_o), 0);
        check("final_scan_cnt", 32'(scan_cnt_o), 32'(m_scan_cnt));
        check("final_timeout", 32'(timeout_o), 32'(m_timeout));
        read_burst(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
